// File: rtl/mutator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mutator_pkg
// Brief    : Shared FSM encoding and width helper for chromosome_mutator.
// Revision : 1.0 - initial release
// ============================================================================
package mutator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mutation_decision.sv
`default_nettype none
// ============================================================================
// Module   : mutation_decision
// Brief    : Unsigned random < rate compare producing the per-gene flip bit.
// Revision : 1.0 - initial release
// ============================================================================
module mutation_decision #(
    parameter int Width = 8
) (
    input  logic [Width-1:0] random,
    input  logic [Width-1:0] rate_q,
    output logic             flip
);

    assign flip = (random < rate_q);

endmodule
`default_nettype wire

// File: rtl/chromosome_mutator.sv
`default_nettype none
// ============================================================================
// Module   : chromosome_mutator
// Brief    : Walks a chromosome one gene per cycle, flipping genes whose random
//            sample is below the rate. Optional MUTATOR_FLIP_COUNT_EN adds a
//            count of flipped genes on port flips.
// Revision : 1.0 - initial release
// ============================================================================
module chromosome_mutator
    import mutator_pkg::*;
#(
    parameter int Width = 8,
    parameter int Genes = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [Genes-1:0]                     chromosome_in,
    input  logic [Width-1:0]                     rate,
    output logic                                 rnd_ce,
    input  logic [Width-1:0]                     random,
    output logic                                 out_valid,
    input  logic                                 out_ready,
`ifdef MUTATOR_FLIP_COUNT_EN
    output logic [cnt_width(Genes+1)-1:0]        flips,
`endif
    output logic [Genes-1:0]                     chromosome_out
);

    localparam int                 c_IDX_W = cnt_width(Genes);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(Genes - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [Genes-1:0]   r_work;
    logic [Width-1:0]   r_rate;
    logic               w_flip;
    logic               w_accept;

    mutation_decision #(
        .Width (Width)
    ) u_decision (
        .random (random),
        .rate_q (r_rate),
        .flip   (w_flip)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs are pure state decodes so random never reaches a port.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        rnd_ce      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                rnd_ce = 1'b1;
                if (r_idx == c_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = in_valid && (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_work <= '0;
            r_rate <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_work <= chromosome_in;
            r_rate <= rate;
            r_idx  <= '0;
        end else if (r_state == ST_RUN) begin
            r_work <= r_work ^ (Genes'(w_flip) << r_idx);
            if (r_idx != c_LAST) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign chromosome_out = r_work;

`ifdef MUTATOR_FLIP_COUNT_EN
    localparam int c_FLIP_W = cnt_width(Genes + 1);

    logic [c_FLIP_W-1:0] r_flips;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flips <= '0;
        end else if (w_accept) begin
            r_flips <= '0;
        end else if (r_state == ST_RUN) begin
            r_flips <= r_flips + c_FLIP_W'(w_flip);
        end
    end

    assign flips = r_flips;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chromosome_mutator.sv
`default_nettype none
// ============================================================================
// Module   : tb_chromosome_mutator
// Brief    : Table-driven scoreboard bench for chromosome_mutator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chromosome_mutator;

    localparam int c_W = 8;
    localparam int c_G = 16;
    localparam int c_FW = $clog2(c_G + 1);

    typedef struct {
        logic [c_G-1:0] chrom;
        logic [c_W-1:0] rate;
        int             mode;   // 0 free-running, 1 constant va, 2 va even / vb odd
        logic [c_W-1:0] va;
        logic [c_W-1:0] vb;
        logic [c_G-1:0] exp;
        int             exp_flips;
    } vec_t;

    typedef struct {
        logic [c_G-1:0] data;
        int             nflips;
    } sb_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [c_G-1:0]  chromosome_in = '0;
    logic [c_W-1:0]  rate = '0;
    logic            rnd_ce;
    logic [c_W-1:0]  random = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [c_G-1:0]  chromosome_out;
`ifdef MUTATOR_FLIP_COUNT_EN
    logic [c_FW-1:0] flips;
`endif

    chromosome_mutator #(.Width(c_W), .Genes(c_G)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .chromosome_in  (chromosome_in),
        .rate           (rate),
        .rnd_ce         (rnd_ce),
        .random         (random),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
`ifdef MUTATOR_FLIP_COUNT_EN
        .flips          (flips),
`endif
        .chromosome_out (chromosome_out)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    vec_t vecs[8];
    vec_t cur;
    sb_t  sbq[$];
    int   gcnt = 0;
    int   ce_cnt = 0;
    int   acc_cyc = 0;
    int   acc_n = 0;
    int   last_acc = -1;
    bit   b2b = 1'b0;
    bit   prev_ov = 1'b0;
    int   done_n = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // Generator model, scoreboard and timing monitor, all on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            sbq.delete();
            ce_cnt = 0;
            gcnt = 0;
            prev_ov = 1'b0;
        end else begin
            if (in_ready) gcnt = 0;
            if (rnd_ce) begin
                ce_cnt++;
                case (cur.mode)
                    0: random = c_W'($urandom);
                    1: random = cur.va;
                    default: random = (gcnt % 2 == 0) ? cur.va : cur.vb;
                endcase
                gcnt++;
            end
            if (in_valid && in_ready) begin
                sb_t e;
                e.data = cur.exp;
                e.nflips = cur.exp_flips;
                sbq.push_back(e);
                if (b2b && last_acc >= 0)
                    check((cyc + 1 - last_acc) == c_G + 2, "b2b_gap", cyc + 1 - last_acc, c_G + 2);
                last_acc = cyc + 1;
                acc_cyc = cyc + 1;
                acc_n++;
                ce_cnt = 0;
            end
            if (out_valid && !prev_ov) begin
                check((cyc - acc_cyc) == c_G, "latency", cyc - acc_cyc, c_G);
                check(ce_cnt == c_G, "rnd_ce_cycles", ce_cnt, c_G);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check(1'b0, "sb_empty", 0, 1);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    check(chromosome_out == e.data, "data", int'(chromosome_out), int'(e.data));
`ifdef MUTATOR_FLIP_COUNT_EN
                    check(int'(flips) == e.nflips, "flips", int'(flips), e.nflips);
`endif
                end
                done_n++;
            end
            prev_ov = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one chromosome, scramble inputs after acceptance, wait for return to IDLE.
    task automatic launch(input vec_t v, input int release_wait);
        int t;
        cur = v;
        chromosome_in = v.chrom;
        rate = v.rate;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin tick(); t++; end
        tick();
        in_valid = 1'b0;
        chromosome_in = ~v.chrom;
        rate = ~v.rate;
        if (release_wait != 0) return;
        t = 0;
        while (!out_valid && t < 100) begin tick(); t++; end
        check(out_valid, "out_valid_timeout", int'(out_valid), 1);
        t = 0;
        while (!in_ready && t < 20) begin tick(); t++; end
        check(in_ready, "return_idle", int'(in_ready), 1);
    endtask

    initial begin
        logic [c_G-1:0] held;
        int t;
        vecs[0] = '{16'hA5A5, 8'h00, 0, 8'h00, 8'h00, 16'hA5A5, 0};
        vecs[1] = '{16'hA5A5, 8'hFF, 1, 8'h00, 8'h00, 16'h5A5A, 16};
        vecs[2] = '{16'h0000, 8'h80, 2, 8'h10, 8'h90, 16'h5555, 8};
        vecs[3] = '{16'h1234, 8'hFF, 1, 8'hFF, 8'hFF, 16'h1234, 0};
        vecs[4] = '{16'hFFFF, 8'h11, 1, 8'h10, 8'h10, 16'h0000, 16};
        vecs[5] = '{16'hC3C3, 8'h10, 1, 8'h10, 8'h10, 16'hC3C3, 0};
        vecs[6] = '{16'hFFFF, 8'h80, 2, 8'h7F, 8'h80, 16'hAAAA, 8};
        vecs[7] = '{16'h0F0F, 8'h01, 2, 8'h00, 8'h01, 16'h5A5A, 8};
        cur = vecs[0];

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check(in_ready == 1'b1, "rst_in_ready", int'(in_ready), 1);
        check(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
        check(rnd_ce == 1'b0, "rst_rnd_ce", int'(rnd_ce), 0);
        check(chromosome_out == '0, "rst_chrom_out", int'(chromosome_out), 0);

        for (int i = 0; i < 8; i++) launch(vecs[i], 0);
        tick();

        // Stall in DONE for five cycles.
        out_ready = 1'b0;
        launch(vecs[2], 1);
        t = 0;
        while (!out_valid && t < 100) begin tick(); t++; end
        held = chromosome_out;
        for (int k = 0; k < 5; k++) begin
            tick();
            check(out_valid == 1'b1 && chromosome_out == held, "stall_hold",
                  int'(chromosome_out), int'(held));
            check(in_ready == 1'b0 && rnd_ce == 1'b0, "stall_ctrl",
                  int'({in_ready, rnd_ce}), 0);
        end
        out_ready = 1'b1;
        tick();
        check(in_ready == 1'b1 && out_valid == 1'b0, "stall_release",
              int'({in_ready, out_valid}), 2);

        // Asynchronous reset in RUN at idx 7.
        launch(vecs[1], 1);
        repeat (7) tick();
        check(rnd_ce == 1'b1, "pre_rst_run", int'(rnd_ce), 1);
        rst = 1'b0;
        #1;
        check(rnd_ce == 1'b0 && out_valid == 1'b0 && in_ready == 1'b1, "async_rst",
              int'({rnd_ce, out_valid, in_ready}), 1);
        @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        launch(vecs[2], 0);
        tick();

        // Back-to-back acceptances.
        cur = vecs[1];
        chromosome_in = vecs[1].chrom;
        rate = vecs[1].rate;
        last_acc = -1;
        acc_n = 0;
        b2b = 1'b1;
        in_valid = 1'b1;
        t = 0;
        while (acc_n < 3 && t < 200) begin tick(); t++; end
        check(acc_n >= 3, "b2b_count", acc_n, 3);
        in_valid = 1'b0;
        b2b = 1'b0;
        t = 0;
        while (sbq.size() != 0 && t < 100) begin tick(); t++; end
        check(sbq.size() == 0, "sb_drained", sbq.size(), 0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
